// File: rtl/sensor_frame_packer.sv
// Collects one result word per channel into a frame and queues frames in a FIFO.
// Define SENSOR_FRAME_TS_EN to stamp each frame with sys_ts at its first strobe.
module sensor_frame_packer #(
    parameter int NUM_CH      = 3,
    parameter int ID_W        = 17,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 7200
) (
    input  logic                        clk_72MHz,
    input  logic                        reset_n,
    input  logic [NUM_CH-1:0]           ch_valid,
    input  logic [NUM_CH*ID_W-1:0]      ch_data,
    input  logic [23:0]                 sys_ts,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_CH-1:0]           out_mask,
    output logic [NUM_CH*ID_W-1:0]      out_data,
    output logic [23:0]                 out_ts,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        clear_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NUM_CH * ID_W;

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [DW-1:0]     data_q, data_d;
    logic [15:0]       timer_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              ovf_q;
    logic [NUM_CH-1:0] take;
    logic              full, pop, push, drop;

    logic [NUM_CH-1:0] mem_mask_q [FIFO_DEPTH];
    logic [DW-1:0]     mem_data_q [FIFO_DEPTH];

    // First strobe per channel wins; IDLE starts a fresh frame.
    always_comb begin
        take = '0;
        if (state_q == IDLE)
            take = ch_valid;
        else if (state_q == COLLECT)
            take = ch_valid & ~mask_q;
    end

    always_comb begin
        data_d = data_q;
        mask_d = (state_q == COMMIT) ? '0 : (mask_q | take);
        for (int i = 0; i < NUM_CH; i++) begin
            if (take[i])
                data_d[i*ID_W +: ID_W] = ch_data[i*ID_W +: ID_W];
            else if (state_q == IDLE)
                data_d[i*ID_W +: ID_W] = '0;
        end
    end

    assign full = (level_q == LW'(FIFO_DEPTH));
    assign pop  = (level_q != '0) && out_ready;
    assign push = (state_q == COMMIT) && (!full || pop);
    assign drop = (state_q == COMMIT) && full && !pop;

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            timer_q <= '0;
        end else begin
            mask_q <= mask_d;
            data_q <= data_d;
            unique case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (|ch_valid)
                        state_q <= COLLECT;
                end
                COLLECT: begin
                    timer_q <= timer_q + 16'd1;
                    if (&mask_q || timer_q == 16'(TIMEOUT_CYC - 1))
                        state_q <= COMMIT;
                end
                COMMIT: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            ovf_q <= drop | (ovf_q & ~clear_overflow);
        end
    end

    always_ff @(posedge clk_72MHz) begin
        if (push) begin
            mem_mask_q[wr_ptr_q] <= mask_q;
            mem_data_q[wr_ptr_q] <= data_q;
        end
    end

    assign out_valid  = (level_q != '0);
    assign out_mask   = out_valid ? mem_mask_q[rd_ptr_q] : '0;
    assign out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

`ifdef SENSOR_FRAME_TS_EN
    logic [23:0] ts_q;
    logic [23:0] mem_ts_q [FIFO_DEPTH];

    always_ff @(posedge clk_72MHz or negedge reset_n) begin
        if (!reset_n)
            ts_q <= '0;
        else if (state_q == IDLE && |ch_valid)
            ts_q <= sys_ts;
    end

    always_ff @(posedge clk_72MHz) begin
        if (push)
            mem_ts_q[wr_ptr_q] <= ts_q;
    end

    assign out_ts = out_valid ? mem_ts_q[rd_ptr_q] : '0;
`else
    logic unused_ts;
    assign unused_ts = ^sys_ts;
    assign out_ts    = '0;
`endif

endmodule
